quadgen_seq: RTL and testbench



---
 rtl/quadgen_seq.sv | 183 ++++++++++++++++++
 tb/tb_quadgen_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/quadgen_seq.sv
// quadgen_seq: WIDTH-bit ADD/SUB/MUL/ACC engine with valid/ready handshakes and an iterative shift-add MUL.
// Build option: define SATURATE_EN to clamp results on carry/borrow/overflow instead of wrapping.
module quadgen_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t             state_r;
   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [2*WIDTH-1:0] prod_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [WIDTH-1:0]   acc_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [WIDTH-1:0]   result_r;
   logic               carry_r;
   logic               zero_r;

   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_s;
   logic [WIDTH-1:0]   acc_base_s;
   logic [WIDTH:0]     acc_sum_s;
   logic [2*WIDTH-1:0] prod_next_s;
   logic               mul_ovf_s;
   logic [WIDTH-1:0]   add_res_s;
   logic [WIDTH-1:0]   sub_res_s;
   logic [WIDTH-1:0]   acc_res_s;
   logic [WIDTH-1:0]   mul_res_s;
   logic [WIDTH-1:0]   op_res_s;
   logic               op_cry_s;
   logic               acc_take_s;

   // Arithmetic for the single-cycle ops, the accumulator update and the next MUL partial product
   always_comb begin
      add_s       = {1'b0, a} + {1'b0, b};
      sub_s       = {1'b0, a} - {1'b0, b};
      acc_base_s  = acc_clr ? ZERO : acc_r;
      acc_sum_s   = {1'b0, acc_base_s} + {1'b0, a};
      prod_next_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
      mul_ovf_s   = |prod_next_s[2*WIDTH-1:WIDTH];
`ifdef SATURATE_EN
      add_res_s   = add_s[WIDTH]     ? ONES : add_s[WIDTH-1:0];
      sub_res_s   = sub_s[WIDTH]     ? ZERO : sub_s[WIDTH-1:0];
      acc_res_s   = acc_sum_s[WIDTH] ? ONES : acc_sum_s[WIDTH-1:0];
      mul_res_s   = mul_ovf_s        ? ONES : prod_next_s[WIDTH-1:0];
`else
      add_res_s   = add_s[WIDTH-1:0];
      sub_res_s   = sub_s[WIDTH-1:0];
      acc_res_s   = acc_sum_s[WIDTH-1:0];
      mul_res_s   = prod_next_s[WIDTH-1:0];
`endif
      op_res_s    = ZERO;
      op_cry_s    = 1'b0;
      case (func)
         2'b00: begin
            op_res_s = add_res_s;
            op_cry_s = add_s[WIDTH];
         end
         2'b01: begin
            op_res_s = sub_res_s;
            op_cry_s = sub_s[WIDTH];
         end
         2'b11: begin
            op_res_s = acc_res_s;
            op_cry_s = acc_sum_s[WIDTH];
         end
         default: begin
            op_res_s = ZERO;
            op_cry_s = 1'b0;
         end
      endcase
      if (state_r == IDLE && in_valid && func == 2'b11) begin
         acc_take_s = 1'b1;
      end else begin
         acc_take_s = 1'b0;
      end
   end

   // Handshake FSM, MUL iteration and registered result/flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= {CW{1'b0}};
         mcand_r     <= {(2*WIDTH){1'b0}};
         prod_r      <= {(2*WIDTH){1'b0}};
         mplier_r    <= ZERO;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= ZERO;
         carry_r     <= 1'b0;
         zero_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  in_ready_r <= 1'b0;
                  if (func == 2'b10) begin
                     state_r  <= BUSY;
                     cnt_r    <= {CW{1'b0}};
                     mcand_r  <= {ZERO, a};
                     mplier_r <= b;
                     prod_r   <= {(2*WIDTH){1'b0}};
                  end else begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                     result_r    <= op_res_s;
                     carry_r     <= op_cry_s;
                     zero_r      <= (op_res_s == ZERO);
                  end
               end
            end
            BUSY: begin
               prod_r   <= prod_next_s;
               mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
               mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == LAST) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
                  result_r    <= mul_res_s;
                  carry_r     <= mul_ovf_s;
                  zero_r      <= (mul_res_s == ZERO);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   // Accumulator: an accepted ACC wins over a plain clear (the clear is folded into acc_base_s)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= ZERO;
      end else if (acc_take_s) begin
         acc_r <= acc_res_s;
      end else if (acc_clr) begin
         acc_r <= ZERO;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign carry     = carry_r;
   assign zero      = zero_r;

endmodule

// File: tb/tb_quadgen_seq.sv
// Directed self-checking bench for quadgen_seq at WIDTH=4; expectations follow SATURATE_EN when defined.
module tb_quadgen_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] func;
   logic [3:0] a;
   logic [3:0] b;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic       carry;
   logic       zero;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SATURATE_EN
   localparam logic [3:0] SUB36 = 4'h0, MUL63 = 4'hF, ACC9 = 4'hF, ADDF1 = 4'hF;
   localparam logic       Z_SUB36 = 1'b1, Z_ADDF1 = 1'b0;
`else
   localparam logic [3:0] SUB36 = 4'hD, MUL63 = 4'h2, ACC9 = 4'h2, ADDF1 = 4'h0;
   localparam logic       Z_SUB36 = 1'b0, Z_ADDF1 = 1'b1;
`endif

   quadgen_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .func(func), .a(a), .b(b), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input string tag, input logic [3:0] r, input logic c, input logic z);
      check({tag, "_res"},   result,    r);
      check({tag, "_carry"}, carry,     c);
      check({tag, "_zero"},  zero,      z);
      check({tag, "_ov"},    out_valid, 1'b1);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_ov_fall"}, out_valid, 1'b0);
      check({tag, "_rdy_back"}, in_ready, 1'b1);
   endtask

   // Issue one request, measure acceptance-to-out_valid latency, then check result and flags
   task automatic do_op(input string tag, input logic [1:0] f, input logic [3:0] x, input logic [3:0] y,
                        input logic clr, input int exp_lat, input logic [3:0] r, input logic c,
                        input logic z, input bit rel);
      int  lat;
      bit  busy_ok;
      check({tag, "_rdy"}, in_ready, 1'b1);
      in_valid = 1'b1; func = f; a = x; b = y; acc_clr = clr;
      step();
      in_valid = 1'b0; acc_clr = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 20) begin
         if (in_ready) busy_ok = 1'b0;
         step();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy_rdy_low"}, busy_ok, 1'b1);
      check({tag, "_done_rdy"}, in_ready, 1'b0);
      expect_res(tag, r, c, z);
      if (rel) release_out(tag);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; func = 2'b00; a = 4'h0; b = 4'h0;
      acc_clr = 1'b0; out_ready = 1'b0;
      step(); step();
      check("rst_rdy",   in_ready,  1'b1);
      check("rst_ov",    out_valid, 1'b0);
      check("rst_res",   result,    4'h0);
      check("rst_carry", carry,     1'b0);
      check("rst_zero",  zero,      1'b0);
      rst_n = 1'b1;
      step();

      do_op("add63", 2'b00, 4'h6, 4'h3, 1'b0, 1, 4'h9, 1'b0, 1'b0, 1'b1);
      do_op("addF1", 2'b00, 4'hF, 4'h1, 1'b0, 1, ADDF1, 1'b1, Z_ADDF1, 1'b1);
      do_op("sub36", 2'b01, 4'h3, 4'h6, 1'b0, 1, SUB36, 1'b1, Z_SUB36, 1'b1);
      do_op("sub55", 2'b01, 4'h5, 4'h5, 1'b0, 1, 4'h0, 1'b0, 1'b1, 1'b1);
      do_op("mul63", 2'b10, 4'h6, 4'h3, 1'b0, 5, MUL63, 1'b1, 1'b0, 1'b1);
      do_op("mul35", 2'b10, 4'h3, 4'h5, 1'b0, 5, 4'hF, 1'b0, 1'b0, 1'b1);

      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      do_op("acc6",  2'b11, 4'h6, 4'h0, 1'b0, 1, 4'h6, 1'b0, 1'b0, 1'b1);
      do_op("acc3",  2'b11, 4'h3, 4'h0, 1'b0, 1, 4'h9, 1'b0, 1'b0, 1'b1);
      do_op("acc9",  2'b11, 4'h9, 4'h0, 1'b0, 1, ACC9, 1'b1, 1'b0, 1'b1);
      do_op("accc5", 2'b11, 4'h5, 4'h0, 1'b1, 1, 4'h5, 1'b0, 1'b0, 1'b1);
      do_op("add11", 2'b00, 4'h1, 4'h1, 1'b0, 1, 4'h2, 1'b0, 1'b0, 1'b1);
      do_op("acc1",  2'b11, 4'h1, 4'h0, 1'b0, 1, 4'h6, 1'b0, 1'b0, 1'b1);

      // Back-pressure in DONE: result held, new request ignored until released
      do_op("add22", 2'b00, 4'h2, 4'h2, 1'b0, 1, 4'h4, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; func = 2'b00; a = 4'h7; b = 4'h7;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_res("hold", 4'h4, 1'b0, 1'b0);
         check("hold_rdy", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("hold_idle_ov", out_valid, 1'b0);
      check("hold_idle_rdy", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      expect_res("add77", 4'hE, 1'b0, 1'b0);
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      expect_res("clr_pending", 4'hE, 1'b0, 1'b0);
      release_out("add77");
      do_op("acc3c", 2'b11, 4'h3, 4'h0, 1'b0, 1, 4'h3, 1'b0, 1'b0, 1'b1);

      // Reset two cycles into a MUL
      in_valid = 1'b1; func = 2'b10; a = 4'h6; b = 4'h3;
      step();
      in_valid = 1'b0;
      step(); step();
      rst_n = 1'b0;
      #1;
      check("mrst_ov",    out_valid, 1'b0);
      check("mrst_res",   result,    4'h0);
      check("mrst_carry", carry,     1'b0);
      check("mrst_zero",  zero,      1'b0);
      check("mrst_rdy",   in_ready,  1'b1);
      step();
      rst_n = 1'b1;
      step();
      do_op("post_add", 2'b00, 4'h1, 4'h1, 1'b0, 1, 4'h2, 1'b0, 1'b0, 1'b1);
      do_op("post_acc", 2'b11, 4'h4, 4'h0, 1'b0, 1, 4'h4, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
